// File: rtl/spiker_adapter_ctrl_pkg.sv
// Shared types and defaults for the spiker run controller and its timeout timer.
package spiker_adapter_ctrl_pkg;

  localparam int unsigned SPIKER_CNT_WIDTH_DEF      = 16;
  localparam int unsigned SPIKER_TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    RUN    = 3'd2,
    SAMPLE = 3'd3,
    HOLD   = 3'd4
  } spiker_run_state_e;

  typedef struct packed {
    logic busy;
    logic valid;
    logic overrun;
    logic timeout;
  } spiker_run_status_t;

  function automatic logic run_state_busy(input spiker_run_state_e st);
    return (st == START) || (st == RUN) || (st == SAMPLE);
  endfunction

endpackage

// File: rtl/spiker_run_timer.sv
// RUN-state watchdog: cleared on entry to RUN, counts RUN cycles, flags the last allowed cycle.
module spiker_run_timer #(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_WIDTH-1:0] LAST_VAL = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE_VAL  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + ONE_VAL;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST_VAL);

endmodule

// File: rtl/spiker_run_ctrl.sv
// Sequences one spiker inference run and the capture of its result vector.
// Optional RUN timeout built only when SPIKER_RUN_TIMEOUT_EN is defined.
module spiker_run_ctrl
  import spiker_adapter_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = SPIKER_CNT_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = SPIKER_TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 ack_i,
  input  logic                 abort_i,
  input  logic                 err_clr_i,
  input  logic                 core_done_i,
  output logic                 core_start_o,
  output logic                 sample_o,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic                 overrun_o,
  output logic                 timeout_o,
  output logic                 irq_o,
  output logic [CNT_WIDTH-1:0] run_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  if ((TIMEOUT_CYCLES < 2) || (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_WIDTH))) begin : g_cfg_chk
    $error("spiker_run_ctrl: TIMEOUT_CYCLES must be >= 2 and < 2**CNT_WIDTH");
  end

  spiker_run_state_e    state_q, state_d;
  spiker_run_status_t   status_q, status_d;
  logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic                 core_start_q, core_start_d;
  logic                 sample_q, sample_d;
  logic                 irq_q, irq_d;

  logic                 overrun_set_s;
  logic                 timeout_set_s;
  logic                 run_cnt_inc_s;
  logic                 timeout_hit_s;

`ifdef SPIKER_RUN_TIMEOUT_EN
  spiker_run_timer #(
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_q == START),
    .en_i     (state_q == RUN),
    .expire_o (timeout_hit_s)
  );
`else
  assign timeout_hit_s = 1'b0;
`endif

  // next-state and event decode; abort beats every other input
  always_comb begin
    state_d       = state_q;
    overrun_set_s = 1'b0;
    timeout_set_s = 1'b0;
    run_cnt_inc_s = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          state_d       = RUN;
          overrun_set_s = start_i;
        end
        RUN: begin
          overrun_set_s = start_i;
          if (core_done_i) begin
            state_d = SAMPLE;
          end else if (timeout_hit_s) begin
            state_d       = IDLE;
            timeout_set_s = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        SAMPLE: begin
          state_d       = HOLD;
          overrun_set_s = start_i;
          run_cnt_inc_s = 1'b1;
        end
        HOLD: begin
          // a start that arrives with the ack is a back-to-back run, not an overrun
          if (ack_i) begin
            state_d = start_i ? START : IDLE;
          end else begin
            state_d       = HOLD;
            overrun_set_s = start_i;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // sticky flags, run counter and output decode from the next state
  always_comb begin
    status_d       = status_q;
    run_cnt_d      = run_cnt_q;
    status_d.busy  = run_state_busy(state_d);
    status_d.valid = (state_d == HOLD);
    if (overrun_set_s) begin
      status_d.overrun = 1'b1;
    end else if (err_clr_i) begin
      status_d.overrun = 1'b0;
    end else begin
      status_d.overrun = status_q.overrun;
    end
    if (timeout_set_s) begin
      status_d.timeout = 1'b1;
    end else if (err_clr_i) begin
      status_d.timeout = 1'b0;
    end else begin
      status_d.timeout = status_q.timeout;
    end
    if (run_cnt_inc_s) begin
      run_cnt_d = run_cnt_q + CNT_ONE;
    end else begin
      run_cnt_d = run_cnt_q;
    end
    core_start_d = (state_d == START);
    sample_d     = (state_d == SAMPLE);
    irq_d        = status_d.valid | status_d.timeout;
  end

  // state and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      status_q     <= '0;
      run_cnt_q    <= '0;
      core_start_q <= 1'b0;
      sample_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      run_cnt_q    <= run_cnt_d;
      core_start_q <= core_start_d;
      sample_q     <= sample_d;
      irq_q        <= irq_d;
    end
  end

  assign core_start_o = core_start_q;
  assign sample_o     = sample_q;
  assign busy_o       = status_q.busy;
  assign valid_o      = status_q.valid;
  assign overrun_o    = status_q.overrun;
  assign timeout_o    = status_q.timeout;
  assign irq_o        = irq_q;
  assign run_cnt_o    = run_cnt_q;

endmodule

// File: tb/tb_spiker_run_ctrl.sv
// Directed bench for spiker_run_ctrl (CNT_WIDTH=4, TIMEOUT_CYCLES=8).
module tb_spiker_run_ctrl;

  localparam int CW = 4;
`ifdef SPIKER_RUN_TIMEOUT_EN
  localparam int T_DONE = 8;
`else
  localparam int T_DONE = 10;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni, start_i, ack_i, abort_i, err_clr_i, core_done_i;
  logic          core_start_o, sample_o, busy_o, valid_o, overrun_o, timeout_o, irq_o;
  logic [CW-1:0] run_cnt_o;

  int            n_chk = 0;
  int            n_bad = 0;
  logic          exp_ovr = 1'b0;
  logic          exp_tmo = 1'b0;
  logic [CW-1:0] exp_cnt = '0;

  spiker_run_ctrl #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ack_i(ack_i),
    .abort_i(abort_i), .err_clr_i(err_clr_i), .core_done_i(core_done_i),
    .core_start_o(core_start_o), .sample_o(sample_o), .busy_o(busy_o),
    .valid_o(valid_o), .overrun_o(overrun_o), .timeout_o(timeout_o),
    .irq_o(irq_o), .run_cnt_o(run_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic cs, input logic smp,
                            input logic bsy, input logic vld);
    check_val({tag, ".core_start"}, 32'(core_start_o), 32'(cs));
    check_val({tag, ".sample"},     32'(sample_o),     32'(smp));
    check_val({tag, ".busy"},       32'(busy_o),       32'(bsy));
    check_val({tag, ".valid"},      32'(valid_o),      32'(vld));
    check_val({tag, ".overrun"},    32'(overrun_o),    32'(exp_ovr));
    check_val({tag, ".timeout"},    32'(timeout_o),    32'(exp_tmo));
    check_val({tag, ".irq"},        32'(irq_o),        32'(vld | exp_tmo));
    check_val({tag, ".run_cnt"},    32'(run_cnt_o),    32'(exp_cnt));
  endtask

  task automatic go_run(input string tag);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    expect_out({tag, ".start"}, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out({tag, ".run"}, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic finish_run(input string tag);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    expect_out({tag, ".sample"}, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    exp_cnt = exp_cnt + 4'd1;
    expect_out({tag, ".hold"}, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic ack_run(input string tag);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    expect_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; ack_i = 1'b0; abort_i = 1'b0;
    err_clr_i = 1'b0; core_done_i = 1'b0;
    tick();
    tick();
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    tick();
    expect_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // basic run with cycle-exact latency, ack at c20
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    expect_out("t2.c1", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 2; c <= T_DONE; c++) begin
      tick();
      expect_out("t2.run", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    expect_out("t2.sample", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    exp_cnt = exp_cnt + 4'd1;
    expect_out("t2.hold0", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = T_DONE + 3; c <= 20; c++) begin
      tick();
      expect_out("t2.hold", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    ack_run("t2");

    // overrun during RUN and in HOLD without ack, clear with set-wins
    go_run("t3");
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    exp_ovr = 1'b1;
    expect_out("t3.ovr_run", 1'b0, 1'b0, 1'b1, 1'b0);
    finish_run("t3");
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    expect_out("t3.ovr_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    start_i = 1'b1;
    err_clr_i = 1'b1;
    tick();
    start_i = 1'b0;
    expect_out("t3.set_wins", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    err_clr_i = 1'b0;
    exp_ovr = 1'b0;
    expect_out("t3.clr", 1'b0, 1'b0, 1'b0, 1'b1);

    // back-to-back: ack and start together in HOLD
    ack_i = 1'b1;
    start_i = 1'b1;
    tick();
    ack_i = 1'b0;
    start_i = 1'b0;
    expect_out("t4.start", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("t4.run", 1'b0, 1'b0, 1'b1, 1'b0);
    finish_run("t4");
    ack_run("t4");

    // reset in the middle of RUN, later done ignored
    go_run("t1");
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    exp_ovr = 1'b1;
    expect_out("t1.run", 1'b0, 1'b0, 1'b1, 1'b0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    exp_ovr = 1'b0;
    exp_cnt = '0;
    expect_out("t1.reset", 1'b0, 1'b0, 1'b0, 1'b0);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    expect_out("t1.done_ign", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // abort coincident with done, abort in HOLD, counter wrap
    go_run("t6");
    abort_i = 1'b1;
    core_done_i = 1'b1;
    tick();
    abort_i = 1'b0;
    core_done_i = 1'b0;
    expect_out("t6.abort_run", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("t6.abort_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    go_run("t6b");
    finish_run("t6b");
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    expect_out("t6.abort_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    while (exp_cnt != 4'd15) begin
      go_run("t6w");
      finish_run("t6w");
      ack_run("t6w");
    end
    go_run("t6z");
    finish_run("t6z");
    check_val("t6.wrap", 32'(run_cnt_o), 32'd0);
    ack_run("t6z");

`ifdef SPIKER_RUN_TIMEOUT_EN
    // timeout after 8 RUN cycles, then done on the 8th cycle wins
    go_run("t5");
    for (int k = 1; k <= 7; k++) begin
      tick();
      expect_out("t5.run", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    tick();
    exp_tmo = 1'b1;
    expect_out("t5.timeout", 1'b0, 1'b0, 1'b0, 1'b0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    exp_tmo = 1'b0;
    expect_out("t5.clr", 1'b0, 1'b0, 1'b0, 1'b0);
    go_run("t5b");
    for (int k = 1; k <= 7; k++) begin
      tick();
      expect_out("t5b.run", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    finish_run("t5b");
    ack_run("t5b");
`else
    // no timer: RUN waits until aborted
    go_run("t5n");
    for (int k = 0; k < 30; k++) begin
      tick();
      expect_out("t5n.run", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    expect_out("t5n.abort", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
